// File: rtl/matmul_loader.sv
// Packs a 32-byte A/B frame into eight words in the engine memory, kicks the engine and
// waits for it to finish. Write appears 1 cycle after lane 3; in_ready is low outside LOAD.
module matmul_loader #(
   parameter logic [9:0] BASE_A  = 10'h000,
   parameter logic [9:0] BASE_B  = 10'h100,
   parameter int         TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        mem_write_en,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_data,
   output logic        mm_kick_start,
   input  logic        mm_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   typedef enum logic [1:0] {LOAD, KICK, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state, state_nxt;
   logic [4:0]    cnt;
   logic [23:0]   pack;
   logic [TW-1:0] tcnt;

   logic          accept, frame_err, last_ok, tmo;
   logic          done_set, tmo_err, tcnt_clr;
   logic [9:0]    wr_addr;

   assign in_ready  = (state == LOAD);
   assign busy      = (state != LOAD) || (cnt != 5'd0);
   assign accept    = in_valid & in_ready;
   assign frame_err = accept & (in_last != (cnt == 5'd31));
   assign last_ok   = accept & in_last & (cnt == 5'd31);
   assign tmo       = (tcnt == T_LAST);
   // words 0-3 are A rows, words 4-7 are B columns
   assign wr_addr   = (cnt[4] ? BASE_B : BASE_A) + {8'd0, cnt[3:2]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= LOAD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      mm_kick_start = 1'b0;
      done_set      = 1'b0;
      tmo_err       = 1'b0;
      tcnt_clr      = 1'b0;
      case (state)
         LOAD: begin
            if (last_ok) state_nxt = KICK;
         end
         KICK: begin
            if (mm_ready) begin
               mm_kick_start = 1'b1;
               tcnt_clr      = 1'b1;
               state_nxt     = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!mm_ready) begin
               tcnt_clr  = 1'b1;
               state_nxt = WAIT_DONE;
            end else if (tmo) begin
               tmo_err   = 1'b1;
               state_nxt = LOAD;
            end
         end
         WAIT_DONE: begin
            if (mm_ready) begin
               done_set  = 1'b1;
               state_nxt = LOAD;
            end else if (tmo) begin
               tmo_err   = 1'b1;
               state_nxt = LOAD;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt          <= 5'd0;
         pack         <= 24'd0;
         tcnt         <= '0;
         mem_write_en <= 1'b0;
         mem_addr     <= 10'd0;
         mem_data     <= 32'd0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         mem_write_en <= 1'b0;
         done         <= done_set;
         if (accept) begin
            if (frame_err) begin
               err <= 1'b1;
               cnt <= 5'd0;
            end else begin
               if (cnt == 5'd0) err <= 1'b0;
               cnt <= cnt + 5'd1;
               case (cnt[1:0])
                  2'd0: pack[7:0]   <= in_data;
                  2'd1: pack[15:8]  <= in_data;
                  2'd2: pack[23:16] <= in_data;
                  default: begin
                     mem_write_en <= 1'b1;
                     mem_addr     <= wr_addr;
                     mem_data     <= {in_data, pack};
                  end
               endcase
            end
         end
         if (tmo_err) err <= 1'b1;
         if (tcnt_clr)
            tcnt <= '0;
         else if (state == WAIT_BUSY || state == WAIT_DONE)
            tcnt <= tcnt + T_ONE;
      end
   end

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader: default instance for framing/engine flow, TIMEOUT=16 instance for timeout.
module tb_matmul_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        vld_a, vld_b;
   logic [7:0]  in_data;
   logic        in_last;
   logic        mm_ready;

   logic        rdy_a, we_a, kick_a, busy_a, done_a, err_a;
   logic [9:0]  addr_a;
   logic [31:0] data_a;
   logic        rdy_b, we_b, kick_b, busy_b, done_b, err_b;
   logic [9:0]  addr_b;
   logic [31:0] data_b;

   int tests = 0;
   int fails = 0;

   int          wcnt = 0;
   int          kicks = 0;
   int          dones = 0;
   int          dones_b = 0;
   logic [9:0]  wa [0:127];
   logic [31:0] wd [0:127];

   always #5 clk = ~clk;

   matmul_loader dut_a (
      .clk(clk), .rstn(rstn), .in_valid(vld_a), .in_ready(rdy_a), .in_data(in_data),
      .in_last(in_last), .mem_write_en(we_a), .mem_addr(addr_a), .mem_data(data_a),
      .mm_kick_start(kick_a), .mm_ready(mm_ready), .busy(busy_a), .done(done_a), .err(err_a)
   );

   matmul_loader #(.TIMEOUT(16)) dut_b (
      .clk(clk), .rstn(rstn), .in_valid(vld_b), .in_ready(rdy_b), .in_data(in_data),
      .in_last(in_last), .mem_write_en(we_b), .mem_addr(addr_b), .mem_data(data_b),
      .mm_kick_start(kick_b), .mm_ready(mm_ready), .busy(busy_b), .done(done_b), .err(err_b)
   );

   always @(negedge clk) begin
      if (we_a) begin
         wa[wcnt[6:0]] <= addr_a;
         wd[wcnt[6:0]] <= data_a;
         wcnt <= wcnt + 1;
      end
      if (kick_a) kicks <= kicks + 1;
      if (done_a) dones <= dones + 1;
      if (done_b) dones_b <= dones_b + 1;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sel, input logic [7:0] d, input bit last, input int gap);
      vld_a = 1'b0;
      vld_b = 1'b0;
      repeat (gap) tick();
      in_data = d;
      in_last = last;
      if (sel) vld_b = 1'b1;
      else     vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      vld_b = 1'b0;
   endtask

   task automatic frame(input bit sel, input logic [7:0] first, input int start, input bit gaps);
      for (int k = start; k < 32; k++)
         send(sel, first + 8'(k), k == 31, gaps ? int'($urandom_range(0, 3)) : 0);
   endtask

   task automatic check_writes(input string tag, input int w0, input logic [7:0] first);
      logic [7:0]  b;
      logic [9:0]  ea;
      logic [31:0] ed;
      chk32({tag, "_count"}, 32'(wcnt - w0), 32'd8);
      for (int w = 0; w < 8; w++) begin
         b  = first + 8'(4 * w);
         ed = {b + 8'd3, b + 8'd2, b + 8'd1, b};
         ea = (w < 4) ? 10'(w) : 10'h100 + 10'(w - 4);
         chk32({tag, "_addr"}, {22'd0, wa[w0 + w]}, {22'd0, ea});
         chk32({tag, "_data"}, wd[w0 + w], ed);
      end
   endtask

   // Engine model: ready drops 2 cycles after the kick cycle and returns n cycles later.
   task automatic engine(input int n);
      repeat (2) tick();
      mm_ready = 1'b0;
      chk1("busy_in_wait", busy_a, 1'b1);
      repeat (n) tick();
      chk1("no_done_early", done_a, 1'b0);
      mm_ready = 1'b1;
      tick();
      chk1("done_pulse", done_a, 1'b1);
      chk1("ready_after_done", rdy_a, 1'b1);
      tick();
      chk1("done_one_cycle", done_a, 1'b0);
   endtask

   initial begin
      int w0, k0, d0;
      rstn = 1'b0;
      vld_a = 1'b0;
      vld_b = 1'b0;
      in_data = 8'd0;
      in_last = 1'b0;
      mm_ready = 1'b1;
      repeat (2) tick();

      chk1("rst_in_ready", rdy_a, 1'b1);
      chk1("rst_we", we_a, 1'b0);
      chk32("rst_addr", {22'd0, addr_a}, 32'd0);
      chk32("rst_data", data_a, 32'd0);
      chk1("rst_kick", kick_a, 1'b0);
      chk1("rst_busy", busy_a, 1'b0);
      chk1("rst_done", done_a, 1'b0);
      chk1("rst_err", err_a, 1'b0);
      rstn = 1'b1;
      tick();

      // full-rate frame 0x01..0x20
      w0 = wcnt; k0 = kicks; d0 = dones;
      frame(1'b0, 8'h01, 0, 1'b0);
      chk1("t1_kick_now", kick_a, 1'b1);
      chk1("t1_in_ready_low", rdy_a, 1'b0);
      chk1("t1_w7_we", we_a, 1'b1);
      chk32("t1_w7_addr", {22'd0, addr_a}, 32'h103);
      chk32("t1_w7_data", data_a, 32'h201F1E1D);
      engine(60);
      check_writes("t1", w0, 8'h01);
      chk32("t1_w0_lit", wd[w0], 32'h04030201);
      chk32("t1_w3_lit", wd[w0 + 3], 32'h100F0E0D);
      chk32("t1_kicks", 32'(kicks - k0), 32'd1);
      chk32("t1_dones", 32'(dones - d0), 32'd1);
      chk1("t1_err", err_a, 1'b0);

      // same frame with valid gaps
      w0 = wcnt; k0 = kicks;
      frame(1'b0, 8'h01, 0, 1'b1);
      engine(12);
      check_writes("t2", w0, 8'h01);
      chk32("t2_kicks", 32'(kicks - k0), 32'd1);

      // in_last on byte 9
      w0 = wcnt; k0 = kicks;
      for (int k = 0; k < 10; k++) send(1'b0, 8'h51 + 8'(k), k == 9, 0);
      chk1("t3_err_set", err_a, 1'b1);
      repeat (3) tick();
      chk32("t3_writes", 32'(wcnt - w0), 32'd2);
      chk32("t3_w1_addr", {22'd0, wa[w0 + 1]}, 32'h001);
      chk32("t3_w1_data", wd[w0 + 1], 32'h58575655);
      chk32("t3_no_kick", 32'(kicks - k0), 32'd0);
      chk1("t3_in_ready", rdy_a, 1'b1);
      chk1("t3_not_busy", busy_a, 1'b0);
      w0 = wcnt;
      send(1'b0, 8'h61, 1'b0, 0);
      chk1("t3_err_clear", err_a, 1'b0);
      chk1("t3_busy", busy_a, 1'b1);
      frame(1'b0, 8'h61, 1, 1'b0);
      engine(10);
      check_writes("t3c", w0, 8'h61);

      // engine not ready at kick time
      k0 = kicks;
      mm_ready = 1'b0;
      frame(1'b0, 8'h21, 0, 1'b0);
      chk1("t4_no_kick", kick_a, 1'b0);
      repeat (19) tick();
      chk32("t4_kicks_held", 32'(kicks - k0), 32'd0);
      chk1("t4_still_kick", rdy_a, 1'b0);
      mm_ready = 1'b1;
      #1;
      chk1("t4_kick_on_ready", kick_a, 1'b1);
      engine(5);
      chk32("t4_kicks", 32'(kicks - k0), 32'd1);

      // timeout in WAIT_BUSY on the TIMEOUT=16 instance
      frame(1'b1, 8'h91, 0, 1'b0);
      chk1("t5_kick", kick_b, 1'b1);
      repeat (16) tick();
      chk1("t5_no_err_yet", err_b, 1'b0);
      chk1("t5_waiting", rdy_b, 1'b0);
      tick();
      chk1("t5_err", err_b, 1'b1);
      chk1("t5_back_load", rdy_b, 1'b1);
      chk32("t5_no_done", 32'(dones_b), 32'd0);

      // reset mid-frame
      for (int k = 0; k < 14; k++) send(1'b0, 8'h71 + 8'(k), 1'b0, 0);
      rstn = 1'b0;
      #1;
      chk1("t6_in_ready", rdy_a, 1'b1);
      chk1("t6_busy", busy_a, 1'b0);
      chk1("t6_we", we_a, 1'b0);
      chk32("t6_addr", {22'd0, addr_a}, 32'd0);
      chk32("t6_data", data_a, 32'd0);
      chk1("t6_err_b", err_b, 1'b0);
      #4;
      rstn = 1'b1;
      tick();
      w0 = wcnt;
      frame(1'b0, 8'h81, 0, 1'b0);
      engine(8);
      check_writes("t6", w0, 8'h81);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
